// File: rtl/multi_debouncer.sv
// ---------------------------------------------------------------------------
// multi_debouncer
//
// N-channel debouncer for buttons, switches and other slow mechanical inputs.
// Each channel is synchronised with two flops.
//
// Each channel has a small stability counter. The counter advances on a
// shared millisecond tick. A new level is accepted once the synchronised
// input has differed from the debounced level for DEBOUNCE_MS consecutive
// ticks. Rising and falling strobes are registered. Each strobe is high for
// exactly one cycle, on the same edge as the level change.
//
// Optional feature, enabled by defining the macro DEBOUNCE_HOLD_EN:
//   Hold/auto-repeat detection. hold_tick pulses once after HOLD_MS ticks of
//   continuous high. After that it pulses every REPEAT_MS ticks (0 = no
//   repeat). Without the macro, hold_tick is tied to 0 and HOLD_MS and
//   REPEAT_MS have no effect.
//
// Parameters:
//   CHANNELS     number of independent channels (>= 1)
//   CLK_FREQ     clk frequency in Hz; CLK_FREQ/1000 must be >= 2
//   DEBOUNCE_MS  stable time required, in ms ticks (>= 1)
//   HOLD_MS      hold-detect time in ms ticks (DEBOUNCE_HOLD_EN only)
//   REPEAT_MS    auto-repeat period in ms ticks, 0 disables (DEBOUNCE_HOLD_EN only)
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   noisy_in   raw asynchronous inputs, one bit per channel
//   clean_out  debounced level per channel
//   rise_tick  1-cycle strobe when clean_out goes 0->1
//   fall_tick  1-cycle strobe when clean_out goes 1->0
//   hold_tick  1-cycle hold/repeat strobe (constant 0 without DEBOUNCE_HOLD_EN)
// ---------------------------------------------------------------------------
module multi_debouncer #(
    parameter int CHANNELS    = 4,
    parameter int CLK_FREQ    = 100_000_000,
    parameter int DEBOUNCE_MS = 10,
    parameter int HOLD_MS     = 1000,
    parameter int REPEAT_MS   = 200
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] noisy_in,
    output logic [CHANNELS-1:0] clean_out,
    output logic [CHANNELS-1:0] rise_tick,
    output logic [CHANNELS-1:0] fall_tick,
    output logic [CHANNELS-1:0] hold_tick
);

    localparam int TICK_CYCLES = CLK_FREQ / 1000;
    localparam int PW          = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int CW          = $clog2(DEBOUNCE_MS + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_MS - 1);

    logic [PW-1:0]               presc;
    logic                        ms_tick;
    logic [CHANNELS-1:0]         sync_meta;
    logic [CHANNELS-1:0]         sync_q;
    logic [CHANNELS-1:0][CW-1:0] cnt;

    // The ms tick is decoded from the prescaler. It is high in the cycle
    // where the prescaler sits at its last value, so every channel sees the
    // same tick on the same edge.
    assign ms_tick = (presc == PRESC_LAST);

    // Shared free-running millisecond prescaler. It is never gated, so the
    // timebase is the same for every channel whatever the inputs do.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (ms_tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Two-flop synchroniser per channel. Only sync_q is used downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= noisy_in;
            sync_q    <= sync_meta;
        end
    end

    // Stability counter and debounced level.
    // Any cycle where the input agrees with the current level clears the
    // count. This makes a bounce back restart the wait. The count only
    // advances on ms ticks. It is reset when a new level is accepted, so it
    // never reaches DEBOUNCE_MS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            clean_out <= '0;
            rise_tick <= '0;
            fall_tick <= '0;
        end else begin
            rise_tick <= '0;
            fall_tick <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                if (sync_q[i] == clean_out[i]) begin
                    cnt[i] <= '0;
                end else if (ms_tick) begin
                    if (cnt[i] == CNT_LAST) begin
                        clean_out[i] <= sync_q[i];
                        cnt[i]       <= '0;
                        rise_tick[i] <= sync_q[i];
                        fall_tick[i] <= ~sync_q[i];
                    end else begin
                        cnt[i] <= cnt[i] + CW'(1);
                    end
                end
            end
        end
    end

`ifdef DEBOUNCE_HOLD_EN
    localparam int HOLD_SPAN = (HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS;
    localparam int HW        = $clog2(HOLD_SPAN + 1);

    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_MS - 1);
    localparam logic [HW-1:0] REPEAT_LAST = HW'((REPEAT_MS > 0) ? (REPEAT_MS - 1) : 0);

    typedef enum logic {
        HOLD_WAIT,
        HOLD_REPEAT
    } hold_state_t;

    hold_state_t                 hold_state [CHANNELS];
    logic [CHANNELS-1:0][HW-1:0] hold_cnt;

    // Per-channel hold/repeat tracker.
    // While the level is low, the tracker is parked in HOLD_WAIT with a zero
    // count, so a re-press always waits the full HOLD_MS again. The tick on
    // the rising edge itself is not counted, because clean_out is still low
    // on that edge. As a result, hold_tick can never coincide with rise_tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt  <= '0;
            hold_tick <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                hold_state[i] <= HOLD_WAIT;
            end
        end else begin
            hold_tick <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                if (!clean_out[i]) begin
                    hold_cnt[i]   <= '0;
                    hold_state[i] <= HOLD_WAIT;
                end else if (ms_tick) begin
                    case (hold_state[i])
                        HOLD_WAIT: begin
                            if (hold_cnt[i] == HOLD_LAST) begin
                                hold_tick[i]  <= 1'b1;
                                hold_cnt[i]   <= '0;
                                hold_state[i] <= HOLD_REPEAT;
                            end else begin
                                hold_cnt[i] <= hold_cnt[i] + HW'(1);
                            end
                        end
                        HOLD_REPEAT: begin
                            if (REPEAT_MS > 0) begin
                                if (hold_cnt[i] == REPEAT_LAST) begin
                                    hold_tick[i] <= 1'b1;
                                    hold_cnt[i]  <= '0;
                                end else begin
                                    hold_cnt[i] <= hold_cnt[i] + HW'(1);
                                end
                            end
                        end
                        default: begin
                            hold_state[i] <= HOLD_WAIT;
                        end
                    endcase
                end
            end
        end
    end
`else
    // Hold feature not built. The hold parameters are only referenced here
    // to keep the default build free of unused-parameter warnings. The
    // AND with 1'b0 makes the result a constant zero.
    assign hold_tick = {CHANNELS{1'b0 & (HOLD_MS[0] | REPEAT_MS[0])}};
`endif

endmodule

// File: tb/tb_multi_debouncer.sv
// ---------------------------------------------------------------------------
// tb_multi_debouncer
//
// Self-checking bench for multi_debouncer.
// Configuration: CHANNELS=4, CLK_FREQ=10_000 (10 cycles per ms tick),
// DEBOUNCE_MS=3, HOLD_MS=5, REPEAT_MS=2.
//
// A timing model predicts every output on every cycle out of reset. It
// works from edge counts rather than a per-channel counter:
//   - the ms tick falls on every 10th edge after reset release;
//   - the synchronised input is the raw input from two edges earlier;
//   - a level flips when the current disagreement run has spanned
//     DEBOUNCE_MS ticks.
// Directed scenarios add hand-computed literal checks on top of the model.
// Latencies are counted inclusively, from the edge that first samples the
// new input to the edge where clean_out changes.
// ---------------------------------------------------------------------------
module tb_multi_debouncer;

    localparam int CH        = 4;
    localparam int CLK_FREQ  = 10_000;
    localparam int DEB_MS    = 3;
    localparam int HOLD_MS   = 5;
    localparam int REPEAT_MS = 2;
    localparam int TICK      = CLK_FREQ / 1000;

`ifdef DEBOUNCE_HOLD_EN
    localparam bit HOLD_BUILT = 1'b1;
`else
    localparam bit HOLD_BUILT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CH-1:0] noisy_in;
    logic [CH-1:0] clean_out;
    logic [CH-1:0] rise_tick;
    logic [CH-1:0] fall_tick;
    logic [CH-1:0] hold_tick;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    multi_debouncer #(
        .CHANNELS   (CH),
        .CLK_FREQ   (CLK_FREQ),
        .DEBOUNCE_MS(DEB_MS),
        .HOLD_MS    (HOLD_MS),
        .REPEAT_MS  (REPEAT_MS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .noisy_in (noisy_in),
        .clean_out(clean_out),
        .rise_tick(rise_tick),
        .fall_tick(fall_tick),
        .hold_tick(hold_tick)
    );

    always #5 clk = ~clk;

    // ---------------- check helpers ----------------
    task automatic checkOutput(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkRange(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    int            n;
    logic [CH-1:0] in_q [$];
    logic [CH-1:0] m_sync;
    logic [CH-1:0] m_clean, m_rise, m_fall, m_hold;
    bit            m_ms;
    int            run_start  [CH];
    int            rise_ticks [CH];
    int            k_hold;
    int            ticks_in_run;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n = 0;
            in_q.delete();
            m_clean = '0;
            m_rise  = '0;
            m_fall  = '0;
            m_hold  = '0;
            for (int c = 0; c < CH; c++) begin
                run_start[c]  = -1;
                rise_ticks[c] = 0;
            end
        end else begin
            n++;
            in_q.push_back(noisy_in);
            m_sync = (n >= 3) ? in_q[n-3] : '0;
            m_ms   = ((n % TICK) == 0);
            m_rise = '0;
            m_fall = '0;
            m_hold = '0;
            for (int c = 0; c < CH; c++) begin
                // Hold uses the level as it stood before this edge.
                if (HOLD_BUILT && m_clean[c] && m_ms) begin
                    k_hold = n / TICK - rise_ticks[c];
                    if (k_hold == HOLD_MS ||
                        (REPEAT_MS > 0 && k_hold > HOLD_MS && ((k_hold - HOLD_MS) % REPEAT_MS) == 0))
                        m_hold[c] = 1'b1;
                end
                if (m_sync[c] == m_clean[c]) begin
                    run_start[c] = -1;
                end else begin
                    if (run_start[c] < 0) run_start[c] = n;
                    ticks_in_run = n / TICK - (run_start[c] - 1) / TICK;
                    if (m_ms && ticks_in_run == DEB_MS) begin
                        m_clean[c]   = m_sync[c];
                        m_rise[c]    = m_sync[c];
                        m_fall[c]    = ~m_sync[c];
                        run_start[c] = -1;
                        if (m_sync[c]) rise_ticks[c] = n / TICK;
                    end
                end
            end
        end
    end

    // ---------------- compare + event monitor ----------------
    int            rise_cnt [CH];
    int            fall_cnt [CH];
    int            hold_cnt [CH];
    int            change_edge [CH];
    int            rise_edge [CH];
    int            fall_edge [CH];
    int            hold_e1 [CH];
    int            hold_e2 [CH];
    logic [CH-1:0] prev_clean = '0;

    always @(posedge clk) begin
        cyc++;
        #1;
        if (rst_n) begin
            checkOutput("clean_out", clean_out, m_clean);
            checkOutput("rise_tick", rise_tick, m_rise);
            checkOutput("fall_tick", fall_tick, m_fall);
            checkOutput("hold_tick", hold_tick, m_hold);
            for (int c = 0; c < CH; c++) begin
                if (clean_out[c] !== prev_clean[c]) change_edge[c] = cyc;
                if (rise_tick[c]) begin rise_cnt[c]++; rise_edge[c] = cyc; end
                if (fall_tick[c]) begin fall_cnt[c]++; fall_edge[c] = cyc; end
                if (hold_tick[c]) begin
                    hold_cnt[c]++;
                    if (hold_cnt[c] == 1) hold_e1[c] = cyc;
                    else if (hold_cnt[c] == 2) hold_e2[c] = cyc;
                end
            end
            prev_clean = clean_out;
        end else begin
            prev_clean = '0;
        end
    end

    // ---------------- stimulus helpers ----------------
    int last_edge;

    task automatic resetCounters();
        for (int c = 0; c < CH; c++) begin
            rise_cnt[c] = 0; fall_cnt[c] = 0; hold_cnt[c] = 0;
            change_edge[c] = 0; rise_edge[c] = 0; fall_edge[c] = 0;
            hold_e1[c] = 0; hold_e2[c] = 0;
        end
    endtask

    task automatic waitCycles(input int num);
        repeat (num) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [CH-1:0] mask, input logic [CH-1:0] val);
        @(negedge clk);
        noisy_in  = (noisy_in & ~mask) | (val & mask);
        last_edge = cyc + 1;
    endtask

    task automatic waitClean(input int c, input logic level, input int budget, output int found);
        found = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (clean_out[c] === level) begin
                found = 1;
                break;
            end
        end
    endtask

    function automatic int sumCounts(input int sel);
        int s = 0;
        for (int c = 0; c < CH; c++)
            s += (sel == 0) ? rise_cnt[c] : (sel == 1) ? fall_cnt[c] : hold_cnt[c];
        return s;
    endfunction

    // ---------------- directed scenarios ----------------
    int e_edge;
    int found;

    initial begin
        rst_n    = 1'b1;
        noisy_in = '0;
        resetCounters();
        #2 rst_n = 1'b0;

        // Reset and idle
        repeat (5) @(negedge clk);
        checkOutput("reset clean_out", clean_out, 4'b0000);
        checkOutput("reset rise_tick", rise_tick, 4'b0000);
        checkOutput("reset fall_tick", fall_tick, 4'b0000);
        checkOutput("reset hold_tick", hold_tick, 4'b0000);
        rst_n = 1'b1;
        resetCounters();
        waitCycles(200);
        checkOutput("idle clean_out", clean_out, 4'b0000);
        checkInt("idle strobe count", sumCounts(0) + sumCounts(1) + sumCounts(2), 0);

        // Clean press and release on ch0
        resetCounters();
        applyStimulus(4'b0001, 4'b0001);
        e_edge = last_edge;
        waitClean(0, 1'b1, 40, found);
        checkInt("ch0 rise seen", found, 1);
        checkRange("ch0 rise latency", change_edge[0] - e_edge + 1, 23, 32);
        checkInt("ch0 rise strobe edge", rise_edge[0], change_edge[0]);
        waitCycles(100);
        checkInt("ch0 rise count", rise_cnt[0], 1);
`ifdef DEBOUNCE_HOLD_EN
        checkInt("ch0 first hold offset", hold_e1[0] - change_edge[0], 50);
        checkInt("ch0 repeat gap", hold_e2[0] - hold_e1[0], 20);
`else
        checkInt("ch0 hold count", hold_cnt[0], 0);
`endif
        applyStimulus(4'b0001, 4'b0000);
        e_edge = last_edge;
        waitClean(0, 1'b0, 40, found);
        checkInt("ch0 fall seen", found, 1);
        checkRange("ch0 fall latency", change_edge[0] - e_edge + 1, 23, 32);
        checkInt("ch0 fall strobe edge", fall_edge[0], change_edge[0]);
        checkInt("ch0 fall count", fall_cnt[0], 1);
        resetCounters();
        waitCycles(100);
        checkInt("ch0 hold after release", hold_cnt[0], 0);

        // Glitch rejection on ch1: 15 sampled cycles high
        resetCounters();
        applyStimulus(4'b0010, 4'b0010);
        waitCycles(14);
        applyStimulus(4'b0010, 4'b0000);
        waitCycles(60);
        checkOutput("glitch clean_out", clean_out, 4'b0000);
        checkInt("glitch ch1 strobes", rise_cnt[1] + fall_cnt[1], 0);

        // Bounce burst on ch2: 5-cycle levels for 100 cycles, then high
        resetCounters();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(4'b0100, (i % 2 == 0) ? 4'b0100 : 4'b0000);
            waitCycles(4);
        end
        applyStimulus(4'b0100, 4'b0100);
        e_edge = last_edge;
        waitClean(2, 1'b1, 40, found);
        checkInt("bounce ch2 rise seen", found, 1);
        checkRange("bounce ch2 latency", change_edge[2] - e_edge + 1, 23, 32);
        waitCycles(40);
        checkInt("bounce ch2 rise count", rise_cnt[2], 1);
        checkInt("bounce ch2 fall count", fall_cnt[2], 0);

        // Simultaneous ch0 + ch3
        resetCounters();
        applyStimulus(4'b1001, 4'b1001);
        waitClean(0, 1'b1, 40, found);
        checkInt("simul ch0 rise seen", found, 1);
        waitCycles(2);
        checkInt("simul ch3 same edge", change_edge[3], change_edge[0]);
        checkOutput("simul clean_out", clean_out, 4'b1101);
        checkInt("simul ch1/ch2 strobes", rise_cnt[1] + fall_cnt[1] + rise_cnt[2] + fall_cnt[2], 0);

        // Reset mid-operation, with ch1 part-way through its count
        applyStimulus(4'b0010, 4'b0010);
        waitCycles(10);
        checkOutput("pre-reset clean_out", clean_out, 4'b1101);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("mid reset clean_out", clean_out, 4'b0000);
        checkOutput("mid reset rise_tick", rise_tick, 4'b0000);
        checkOutput("mid reset fall_tick", fall_tick, 4'b0000);
        checkOutput("mid reset hold_tick", hold_tick, 4'b0000);
        noisy_in = '0;
        waitCycles(3);
        rst_n = 1'b1;
        resetCounters();
        waitCycles(60);
        checkOutput("post reset clean_out", clean_out, 4'b0000);
        checkInt("post reset strobes", sumCounts(0) + sumCounts(1), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net in case anything above stalls
    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout, expected completion (cycle %0d)", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
